pe_regfile_rot: RTL and testbench
=================================

Name: pe_regfile_rot

Overview:
- Parametrised next-generation CGRA PE register file.
- Sits between the PE's neighbour edges/bus and its FU.
- Captures one neighbour word and one FU write-back per cycle, and feeds two FU operands.
- Drives one word onto selected output edges.
- Adds over the previous generation: async reset, per-register valid bits, a rotating base for modulo-scheduled loops, write-collision resolution, and select-error detection.

Parameters:
DATA_W, 32, datapath width in bits
DEPTH, 64, number of registers (power of two, >=2)
ADDR_W, 6, log2(DEPTH)
N_EDGE, 4, number of neighbour input/output channels (edges plus bus)

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  asynchronous active-high reset
edge_in  in  N_EDGE*DATA_W  packed neighbour inputs, channel k at bits [k*DATA_W +: DATA_W]
in_sel  in  N_EDGE  one-hot channel select for the neighbour write
in_we  in  1  neighbour write enable
put_in_addr  in  ADDR_W  logical address for the neighbour write
wb_en  in  1  FU write-back enable
wb_addr  in  ADDR_W  logical address for the write-back
wb_data  in  DATA_W  FU result
rd1_byp, rd2_byp  in  N_EDGE  one-hot operand bypass select; all-zero selects the register file
rd1_addr, rd2_addr  in  ADDR_W  logical operand read addresses
rd1_data, rd2_data  out  DATA_W  FU operands
rd1_valid, rd2_valid  out  1  operand valid
send_addr  in  ADDR_W  logical address of the word to send
out_en  in  N_EDGE  per-channel output enable
edge_out  out  N_EDGE*DATA_W  packed outputs; channel k = reg[send] when out_en[k], else 0
rot_step  in  1  advance rotating base by 1
inv_all  in  1  clear all valid bits (loop epilogue)
collision  out  1  registered; pulses for one cycle after a same-address double write
sel_err  out  1  registered; pulses for one cycle after a non-one-hot select

Behaviour:
- Address mapping: phys = (logical + base) mod DEPTH, ADDR_W-bit wrap. Applies to every logical address port, using the current base.
- base: ADDR_W-bit register.
  - rot_step=1 gives base <= base+1 at the edge; DEPTH-1 wraps to 0.
  - Writes in the same cycle use the pre-step base.
- Neighbour write: occurs when in_we=1 and in_sel is exactly one-hot. reg[phys(put_in_addr)] <= selected channel; valid bit <= 1.
  - in_we=1 with in_sel zero or multi-hot: no write; sel_err=1 next cycle.
- Write-back: wb_en=1 gives reg[phys(wb_addr)] <= wb_data; valid <= 1.
- Both writes to the same physical address in one cycle: write-back wins; collision=1 next cycle.
- Reads are combinational from the array; a same-cycle write becomes visible on the next cycle (no internal forwarding).
- Operand mux:
  - rdN_byp one-hot: rdN_data = selected edge_in channel; rdN_valid=1.
  - rdN_byp all-zero: rdN_data = reg[phys(rdN_addr)]; rdN_valid = that register's valid bit.
  - rdN_byp multi-hot: rdN_data=0, rdN_valid=0, sel_err=1 next cycle.
- Send path: edge_out[k] = out_en[k] ? reg[phys(send_addr)] : 0. Multiple out_en bits may be set (broadcast).
- inv_all=1: all valid bits cleared at the edge, data unchanged. A write in the same cycle wins for its own register (valid=1).
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - all registers 0, all valid bits 0, base 0, collision 0, sel_err 0.
  - Consequently rdN_data = 0 unless bypassed, rdN_valid = 0 unless bypassed, edge_out = 0.
  - First writes are accepted on the first rising edge after RST deasserts.
- collision and sel_err are single-cycle pulses, not sticky; both may assert in the same cycle.

Test Plan:
- Reset/basic write: assert RST mid-stream, then release.
  - All outputs 0.
  - in_we=1, in_sel=4'b0010, edge_in ch1=32'hA5A5_0001, put_in_addr=3 -> next cycle, rd1_addr=3 with byp=0 gives rd1_data=32'hA5A5_0001, rd1_valid=1.
- Bypass: rd2_byp=4'b1000, edge_in ch3=32'h0000_BEEF -> rd2_data=32'h0000_BEEF the same cycle, rd2_valid=1.
  - rd2_byp=4'b1001 -> rd2_data=0, rd2_valid=0, sel_err=1 the following cycle.
- Collision: in_we and wb_en both to address 7, wb_data=32'h1111_2222, ch0=32'h3333_4444 -> reg7=32'h1111_2222; collision pulses for one cycle.
- Rotation wrap:
  - Write 32'hCAFE to logical 0 with base=0.
  - Pulse rot_step 64 times -> logical 0 reads 32'hCAFE again.
  - After 1 step, logical 63 reads 32'hCAFE.
  - A write during the rot_step cycle lands at the pre-step mapping.
- Valid/invalidate: write reg 5, then inv_all=1 -> rd1_valid=0 with data retained. inv_all together with wb to reg 5 -> valid=1, new data.
- Send broadcast: out_en=4'b1011, send_addr=5 -> channels 0, 1 and 3 carry reg5; channel 2 = 0. out_en=0 -> all zero.

Source files
------------

// File: rtl/pe_regfile_rot.sv
// CGRA PE register file: neighbour capture, FU write-back, two operand ports and an edge send
// path, with a rotating base for modulo-scheduled loops and per-register valid bits.
module pe_regfile_rot #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned N_EDGE = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [N_EDGE*DATA_W-1:0] edge_in,
  input  logic [N_EDGE-1:0]        in_sel,
  input  logic                     in_we,
  input  logic [ADDR_W-1:0]        put_in_addr,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic [N_EDGE-1:0]        rd1_byp,
  input  logic [N_EDGE-1:0]        rd2_byp,
  input  logic [ADDR_W-1:0]        rd1_addr,
  input  logic [ADDR_W-1:0]        rd2_addr,
  output logic [DATA_W-1:0]        rd1_data,
  output logic [DATA_W-1:0]        rd2_data,
  output logic                     rd1_valid,
  output logic                     rd2_valid,
  input  logic [ADDR_W-1:0]        send_addr,
  input  logic [N_EDGE-1:0]        out_en,
  output logic [N_EDGE*DATA_W-1:0] edge_out,
  input  logic                     rot_step,
  input  logic                     inv_all,
  output logic                     collision,
  output logic                     sel_err
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] base_q;
  logic              collision_q, sel_err_q;

  logic [ADDR_W-1:0] put_phys, wb_phys, rd1_phys, rd2_phys, send_phys;
  logic              in_onehot, rd1_onehot, rd2_onehot, rd1_multi, rd2_multi;
  logic              nb_we, collision_d, sel_err_d;
  logic [DATA_W-1:0] nb_data, send_word;

  function automatic logic is_onehot(input logic [N_EDGE-1:0] v);
    return (v != '0) && ((v & (v - N_EDGE'(1))) == '0);
  endfunction

  // AND-OR mux; only meaningful when the select is one-hot
  function automatic logic [DATA_W-1:0] pick(input logic [N_EDGE*DATA_W-1:0] e,
                                             input logic [N_EDGE-1:0] s);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < N_EDGE; k++) begin
      if (s[k]) r = r | e[k*DATA_W +: DATA_W];
    end
    return r;
  endfunction

  always_comb begin
    put_phys   = put_in_addr + base_q;
    wb_phys    = wb_addr + base_q;
    rd1_phys   = rd1_addr + base_q;
    rd2_phys   = rd2_addr + base_q;
    send_phys  = send_addr + base_q;

    in_onehot  = is_onehot(in_sel);
    rd1_onehot = is_onehot(rd1_byp);
    rd2_onehot = is_onehot(rd2_byp);
    rd1_multi  = (rd1_byp != '0) && !rd1_onehot;
    rd2_multi  = (rd2_byp != '0) && !rd2_onehot;

    nb_we       = in_we && in_onehot;
    nb_data     = pick(edge_in, in_sel);
    collision_d = nb_we && wb_en && (put_phys == wb_phys);
    sel_err_d   = (in_we && !in_onehot) || rd1_multi || rd2_multi;
  end

  always_comb begin
    rd1_data  = '0;
    rd1_valid = 1'b0;
    rd2_data  = '0;
    rd2_valid = 1'b0;
    if (rd1_onehot) begin
      rd1_data  = pick(edge_in, rd1_byp);
      rd1_valid = 1'b1;
    end else if (rd1_byp == '0) begin
      rd1_data  = mem_q[rd1_phys];
      rd1_valid = valid_q[rd1_phys];
    end
    if (rd2_onehot) begin
      rd2_data  = pick(edge_in, rd2_byp);
      rd2_valid = 1'b1;
    end else if (rd2_byp == '0) begin
      rd2_data  = mem_q[rd2_phys];
      rd2_valid = valid_q[rd2_phys];
    end
  end

  always_comb begin
    send_word = mem_q[send_phys];
    edge_out  = '0;
    for (int unsigned k = 0; k < N_EDGE; k++) begin
      if (out_en[k]) edge_out[k*DATA_W +: DATA_W] = send_word;
    end
  end

  // Write-back is applied last so it wins a same-address collision; writes beat inv_all
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      valid_q     <= '0;
      base_q      <= '0;
      collision_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      if (inv_all) valid_q <= '0;
      if (nb_we) begin
        mem_q[put_phys]   <= nb_data;
        valid_q[put_phys] <= 1'b1;
      end
      if (wb_en) begin
        mem_q[wb_phys]   <= wb_data;
        valid_q[wb_phys] <= 1'b1;
      end
      if (rot_step) base_q <= base_q + ADDR_W'(1);
      collision_q <= collision_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign collision = collision_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_pe_regfile_rot.sv
// Directed self-checking bench for pe_regfile_rot (default parameters).
module tb_pe_regfile_rot;
  localparam int DW = 32;
  localparam int NE = 4;
  localparam int AW = 6;

  logic           CLK = 1'b0;
  logic           RST;
  logic [NE*DW-1:0] edge_in;
  logic [NE-1:0]  in_sel, rd1_byp, rd2_byp, out_en;
  logic           in_we, wb_en, rot_step, inv_all;
  logic [AW-1:0]  put_in_addr, wb_addr, rd1_addr, rd2_addr, send_addr;
  logic [DW-1:0]  wb_data, rd1_data, rd2_data;
  logic           rd1_valid, rd2_valid, collision, sel_err;
  logic [NE*DW-1:0] edge_out;

  int n_vec = 0;
  int n_err = 0;

  pe_regfile_rot dut (
    .CLK(CLK), .RST(RST), .edge_in(edge_in), .in_sel(in_sel), .in_we(in_we),
    .put_in_addr(put_in_addr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd1_byp(rd1_byp), .rd2_byp(rd2_byp), .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd1_data(rd1_data), .rd2_data(rd2_data), .rd1_valid(rd1_valid), .rd2_valid(rd2_valid),
    .send_addr(send_addr), .out_en(out_en), .edge_out(edge_out), .rot_step(rot_step),
    .inv_all(inv_all), .collision(collision), .sel_err(sel_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    edge_in = '0; in_sel = '0; in_we = 0; put_in_addr = '0; wb_en = 0; wb_addr = '0;
    wb_data = '0; rd1_byp = '0; rd2_byp = '0; rd1_addr = '0; rd2_addr = '0;
    send_addr = '0; out_en = '0; rot_step = 0; inv_all = 0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled 1 unit later
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [DW-1:0] v);
    edge_in[k*DW +: DW] = v;
  endtask

  initial begin
    idle();
    RST = 1'b1;
    step(); step();
    RST = 1'b0;

    // Something in reg 3, then reset mid-stream
    wb_en = 1; wb_addr = 3; wb_data = 32'hDEAD_0003;
    step(); idle();
    send_addr = 3; out_en = 4'b1111; rd1_addr = 3;
    #1;
    check("pre_rst_send", 128'(edge_out), 128'hDEAD0003_DEAD0003_DEAD0003_DEAD0003);
    RST = 1'b1;
    #1;
    check("rst_edge_out", 128'(edge_out), 128'h0);
    check("rst_rd1_data", 128'(rd1_data), 128'h0);
    check("rst_rd1_valid", 128'(rd1_valid), 128'h0);
    check("rst_flags", 128'({collision, sel_err}), 128'h0);
    step();
    RST = 1'b0; idle();

    // Basic neighbour write
    in_we = 1; in_sel = 4'b0010; set_ch(1, 32'hA5A5_0001); set_ch(0, 32'h1234_5678);
    put_in_addr = 3;
    step(); idle();
    rd1_addr = 3;
    #1;
    check("nb_wr_data", 128'(rd1_data), 128'hA5A5_0001);
    check("nb_wr_valid", 128'(rd1_valid), 128'h1);
    check("nb_wr_no_err", 128'(sel_err), 128'h0);

    // Bypass
    rd2_byp = 4'b1000; set_ch(3, 32'h0000_BEEF);
    #1;
    check("byp_data", 128'(rd2_data), 128'hBEEF);
    check("byp_valid", 128'(rd2_valid), 128'h1);
    rd2_byp = 4'b1001;
    #1;
    check("byp_multi_data", 128'(rd2_data), 128'h0);
    check("byp_multi_valid", 128'(rd2_valid), 128'h0);
    step(); idle();
    check("byp_multi_err", 128'(sel_err), 128'h1);
    step();
    check("sel_err_pulse", 128'(sel_err), 128'h0);

    // Write with empty select: dropped, error flagged
    in_we = 1; in_sel = 4'b0000; set_ch(0, 32'h7777_7777); put_in_addr = 9;
    step(); idle();
    rd1_addr = 9;
    #1;
    check("nosel_err", 128'(sel_err), 128'h1);
    check("nosel_no_write", 128'(rd1_valid), 128'h0);

    // Collision: write-back wins
    in_we = 1; in_sel = 4'b0001; set_ch(0, 32'h3333_4444); put_in_addr = 7;
    wb_en = 1; wb_addr = 7; wb_data = 32'h1111_2222;
    step(); idle();
    rd1_addr = 7;
    #1;
    check("coll_flag", 128'(collision), 128'h1);
    check("coll_no_sel_err", 128'(sel_err), 128'h0);
    check("coll_data", 128'(rd1_data), 128'h1111_2222);
    step();
    check("coll_pulse", 128'(collision), 128'h0);

    // Valid / invalidate
    wb_en = 1; wb_addr = 5; wb_data = 32'h0000_0055;
    step(); idle();
    inv_all = 1;
    step(); idle();
    rd1_addr = 5; rd2_addr = 3;
    #1;
    check("inv_valid", 128'(rd1_valid), 128'h0);
    check("inv_data_kept", 128'(rd1_data), 128'h55);
    inv_all = 1; wb_en = 1; wb_addr = 5; wb_data = 32'h0000_0066;
    step(); idle();
    rd1_addr = 5; rd2_addr = 3;
    #1;
    check("inv_wb_valid", 128'(rd1_valid), 128'h1);
    check("inv_wb_data", 128'(rd1_data), 128'h66);
    check("inv_other_valid", 128'(rd2_valid), 128'h0);

    // Send broadcast
    out_en = 4'b1011; send_addr = 5;
    #1;
    check("send_bcast", 128'(edge_out), 128'h00000066_00000000_00000066_00000066);
    out_en = 4'b0000;
    #1;
    check("send_off", 128'(edge_out), 128'h0);

    // Rotation
    wb_en = 1; wb_addr = 0; wb_data = 32'h0000_CAFE;
    step(); idle();
    rot_step = 1;
    step(); idle();
    rd1_addr = 63; rd2_addr = 0;
    #1;
    check("rot1_l63", 128'(rd1_data), 128'hCAFE);
    check("rot1_l0_valid", 128'(rd2_valid), 128'h0);
    rot_step = 1;
    for (int i = 0; i < 63; i++) step();
    idle();
    rd1_addr = 0;
    #1;
    check("rot64_l0", 128'(rd1_data), 128'hCAFE);
    check("rot64_l0_valid", 128'(rd1_valid), 128'h1);
    // Write in the step cycle uses pre-step base (0): lands at phys 10
    rot_step = 1; wb_en = 1; wb_addr = 10; wb_data = 32'h000B_EEF1;
    step(); idle();
    rd1_addr = 9; rd2_addr = 10;
    #1;
    check("rot_pre_data", 128'(rd1_data), 128'hB_EEF1);
    check("rot_pre_valid", 128'(rd1_valid), 128'h1);
    check("rot_post_slot", 128'(rd2_valid), 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
